ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 25 ++
 rtl/ram_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// Signal bundle between the two RAM requesters, the arbiter and the shared RAM port.
interface ram_arbiter_if;
  logic        req0, req1;
  logic        lock0, lock1;
  logic        we0, we1;
  logic [15:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1;
  logic        done0, done1;
  logic [15:0] rdata;
  logic [15:0] ram_addr;
  logic [15:0] ram_write_data;
  logic        ram_bus_mode;
  logic [15:0] ram_read_data;

  modport master (
    output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, ram_read_data,
    input  gnt0, gnt1, done0, done1, rdata, ram_addr, ram_write_data, ram_bus_mode
  );

  modport slave (
    input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, ram_read_data,
    output gnt0, gnt1, done0, done1, rdata, ram_addr, ram_write_data, ram_bus_mode
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter for a single-port RAM with burst lock and
// configurable read latency; one transaction at a time, all outputs registered.
module ram_arbiter #(
  parameter int RD_LAT = 1
) (
  input logic          clk,
  input logic          reset,
  ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
  localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

  state_t      state_r, state_s;
  logic        owner_r, we_r, last_r, lock_act_r, lock_own_r;
  logic [1:0]  wait_cnt_r;
  logic [15:0] addr_r, wdata_r, rdata_r;
  logic        gnt0_r, gnt1_r, done0_r, done1_r, bus_mode_r;

  logic        lock_hold_s, owner_lock_s, elig0_s, elig1_s, win_s, win_idx_s, win_we_s;
  logic [15:0] win_addr_s, win_wdata_s;

  // Lock filtering, round-robin pick and the winner's request fields
  always_comb begin
    owner_lock_s = owner_r ? bus.lock1 : bus.lock0;
    lock_hold_s  = lock_act_r & (lock_own_r ? bus.lock1 : bus.lock0);
    elig0_s      = bus.req0 & (~lock_hold_s | ~lock_own_r);
    elig1_s      = bus.req1 & (~lock_hold_s | lock_own_r);
    win_s        = elig0_s | elig1_s;
    win_idx_s    = 1'b0;
    win_we_s     = 1'b0;
    win_addr_s   = 16'h0000;
    win_wdata_s  = 16'h0000;
    if (elig0_s && elig1_s) begin
      win_idx_s = ~last_r;
    end else if (elig1_s) begin
      win_idx_s = 1'b1;
    end else begin
      win_idx_s = 1'b0;
    end
    if (win_idx_s) begin
      win_we_s    = bus.we1;
      win_addr_s  = bus.addr1;
      win_wdata_s = bus.wdata1;
    end else begin
      win_we_s    = bus.we0;
      win_addr_s  = bus.addr0;
      win_wdata_s = bus.wdata0;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (win_s) state_s = ACCESS; else state_s = IDLE;
      ACCESS:  if (we_r) state_s = DONE; else state_s = WAIT;
      WAIT:    if (wait_cnt_r == LAST_WAIT) state_s = DONE; else state_s = WAIT;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request latch, RAM strobes, grant/done pulses, read capture and lock/priority bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_r    <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= 16'h0000;
      wdata_r    <= 16'h0000;
      rdata_r    <= 16'h0000;
      wait_cnt_r <= 2'd0;
      gnt0_r     <= 1'b0;
      gnt1_r     <= 1'b0;
      done0_r    <= 1'b0;
      done1_r    <= 1'b0;
      bus_mode_r <= 1'b0;
      last_r     <= 1'b1;
      lock_act_r <= 1'b0;
      lock_own_r <= 1'b0;
    end else begin
      bus_mode_r <= 1'b0;
      done0_r    <= 1'b0;
      done1_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          // the lock survives only while its owner keeps lock asserted
          lock_act_r <= lock_hold_s;
          if (win_s) begin
            owner_r    <= win_idx_s;
            we_r       <= win_we_s;
            addr_r     <= win_addr_s;
            wdata_r    <= win_wdata_s;
            bus_mode_r <= win_we_s;
            gnt0_r     <= ~win_idx_s;
            gnt1_r     <= win_idx_s;
          end
        end
        ACCESS: begin
          wait_cnt_r <= 2'd0;
          if (we_r) begin
            done0_r <= ~owner_r;
            done1_r <= owner_r;
          end
        end
        WAIT: begin
          if (wait_cnt_r == LAST_WAIT) begin
            rdata_r <= bus.ram_read_data;
            done0_r <= ~owner_r;
            done1_r <= owner_r;
          end else begin
            wait_cnt_r <= wait_cnt_r + 2'd1;
          end
        end
        DONE: begin
          gnt0_r     <= 1'b0;
          gnt1_r     <= 1'b0;
          last_r     <= owner_r;
          lock_act_r <= owner_lock_s;
          lock_own_r <= owner_r;
        end
        default: begin
          gnt0_r <= 1'b0;
          gnt1_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt0           = gnt0_r;
  assign bus.gnt1           = gnt1_r;
  assign bus.done0          = done0_r;
  assign bus.done1          = done1_r;
  assign bus.rdata          = rdata_r;
  assign bus.ram_addr       = addr_r;
  assign bus.ram_write_data = wdata_r;
  assign bus.ram_bus_mode   = bus_mode_r;
endmodule
